// File: rtl/burst_packer_pkg.sv
// Shared types and elaboration helpers for the burst packer.
package burst_pkg;

  // Frame-level control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Integer ceiling division, used for burst counts.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_packer_if.sv
// AXI-Stream style handshake bundle used on both sides of the packer.
interface burst_packer_if #(
  parameter int DATA_W = 10,
  parameter int USER_W = 2
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  // Producer side drives payload and valid.
  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  // Consumer side drives ready; the input stream carries no tlast of interest.
  modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/burst_packer_lane_assembler.sv
// Assembly register: collects pixels lane by lane, captures lane-0 sideband,
// and presents the word merged with the pixel currently being written.
module lane_assembler
  import burst_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 10,
  parameter int PIXELS_PER_BURST = 10,
  parameter int USER_WIDTH       = 2,
  parameter int LANE_W           = 4
) (
  input  logic                                       clk,
  input  logic                                       srst,
  input  logic                                       wr_en_i,
  input  logic                                       emit_i,
  input  logic [LANE_W-1:0]                          lane_i,
  input  logic [PIXEL_BIT_WIDTH-1:0]                 pix_i,
  input  logic [USER_WIDTH-1:0]                      user_i,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] word_o,
  output logic [USER_WIDTH-1:0]                      user_o
);

  localparam int PW = PIXEL_BIT_WIDTH;
  localparam int P  = PIXELS_PER_BURST;

  logic [PW*P-1:0]       asm_q;
  logic [USER_WIDTH-1:0] user_q;

  // Merge the incoming pixel into its lane so a completing word is ready this cycle.
  always_comb begin
    word_o = asm_q;
    for (int k = 0; k < P; k++) begin
      if (lane_i == LANE_W'(k)) word_o[k*PW +: PW] = pix_i;
    end
    user_o = (lane_i == '0) ? user_i : user_q;
  end

  // Store lanes as they arrive; clearing on emit zero-pads a short final burst.
  always_ff @(posedge clk) begin
    if (srst) begin
      asm_q  <= '0;
      user_q <= '0;
    end else if (wr_en_i) begin
      if (emit_i) begin
        asm_q  <= '0;
        user_q <= '0;
      end else begin
        for (int k = 0; k < P; k++) begin
          if (lane_i == LANE_W'(k)) asm_q[k*PW +: PW] <= pix_i;
        end
        if (lane_i == '0) user_q <= user_i;
      end
    end
  end

endmodule

// File: rtl/burst_packer.sv
// Packs a one-pixel-per-beat frame into PIXELS_PER_BURST-wide words,
// flags the final word with tlast and signals frame completion on ap_done.
module burst_packer
  import burst_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 10,
  parameter int PIXELS_PER_BURST = 10,
  parameter int USER_WIDTH       = 2,
  parameter int OUT_ROWS         = 10,
  parameter int OUT_COLS         = 10
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        ap_start,
  output logic                        ap_done,
  burst_packer_if.slave               s_axis,
  burst_packer_if.master              m_axis,
  output logic [$clog2(OUT_COLS)-1:0] cnt_col,
  output logic [$clog2(OUT_ROWS)-1:0] cnt_row
);

  localparam int PW           = PIXEL_BIT_WIDTH;
  localparam int P            = PIXELS_PER_BURST;
  localparam int FRAME_PIXELS = OUT_ROWS * OUT_COLS;
  localparam int LANE_W       = cnt_w(P);
  localparam int PIX_W        = cnt_w(FRAME_PIXELS);
  localparam int COL_W        = $clog2(OUT_COLS);
  localparam int ROW_W        = $clog2(OUT_ROWS);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(P - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_COLS - 1);

  state_t                  state_q;
  logic [LANE_W-1:0]       cnt_lane_q;
  logic [PIX_W-1:0]        cnt_pix_q;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  logic                    ap_done_q;
  logic                    m_tvalid_q;
  logic [PW*P-1:0]         m_tdata_q;
  logic [USER_WIDTH-1:0]   m_tuser_q;
  logic                    m_tlast_q;

  logic [PW*P-1:0]         word_d;
  logic [USER_WIDTH-1:0]   user_d;
  logic                    last_pix;
  logic                    word_end;
  logic                    s_ready;
  logic                    s_hs;
  logic                    m_hs;
  logic                    emit;

  assign last_pix = (cnt_pix_q == LAST_PIX);
  assign word_end = (cnt_lane_q == LAST_LANE) || last_pix;
  // Only the completing pixel depends on output space; it looks straight at m_axis.tready
  // so a word can be replaced in the same cycle it leaves.
  assign s_ready  = (state_q == ST_PACK) && (!word_end || !m_tvalid_q || m_axis.tready);
  assign s_hs     = s_ready && s_axis.tvalid;
  assign m_hs     = m_tvalid_q && m_axis.tready;
  assign emit     = s_hs && word_end;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tuser  = m_tuser_q;
  assign m_axis.tlast  = m_tlast_q;
  assign ap_done       = ap_done_q;
  assign cnt_col       = col_q;
  assign cnt_row       = row_q;

  lane_assembler #(
    .PIXEL_BIT_WIDTH (PIXEL_BIT_WIDTH),
    .PIXELS_PER_BURST(PIXELS_PER_BURST),
    .USER_WIDTH      (USER_WIDTH),
    .LANE_W          (LANE_W)
  ) u_asm (
    .clk    (clk),
    .srst   (srst),
    .wr_en_i(s_hs),
    .emit_i (word_end),
    .lane_i (cnt_lane_q),
    .pix_i  (s_axis.tdata),
    .user_i (s_axis.tuser),
    .word_o (word_d),
    .user_o (user_d)
  );

  // Frame FSM, position counters and the output word register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= ST_IDLE;
      cnt_lane_q <= '0;
      cnt_pix_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ap_done_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      ap_done_q <= 1'b0;

      // A reload in the same cycle as a handshake wins, keeping tvalid high.
      if (m_hs) m_tvalid_q <= 1'b0;
      if (emit) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= word_d;
        m_tuser_q  <= user_d;
        m_tlast_q  <= last_pix;
      end

      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            state_q    <= ST_PACK;
            cnt_lane_q <= '0;
            cnt_pix_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
          end
        end
        ST_PACK: begin
          if (s_hs) begin
            cnt_lane_q <= word_end ? '0 : cnt_lane_q + LANE_W'(1);
            if (last_pix) begin
              cnt_pix_q <= '0;
              col_q     <= '0;
              row_q     <= '0;
              state_q   <= ST_DRAIN;
            end else begin
              cnt_pix_q <= cnt_pix_q + PIX_W'(1);
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (m_hs) state_q <= ST_DONE;
        end
        ST_DONE: begin
          ap_done_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_packer.sv
// Bench for burst_packer: a 10x10 instance and a 3x7 instance, directed frames,
// and a pixel-list model that predicts every output word.
module tb_burst_packer;
  import burst_pkg::*;

  localparam int PW  = 10;
  localparam int P   = 10;
  localparam int UW  = 2;
  localparam int WW  = PW * P;
  localparam int A_C = 10;
  localparam int A_F = 100;
  localparam int A_B = ceil_div(A_F, P);
  localparam int B_C = 7;
  localparam int B_F = 21;
  localparam int B_B = ceil_div(B_F, P);

  logic clk = 1'b0;
  logic srst;
  logic a_start, a_done, b_start, b_done;
  logic [3:0] a_col, a_row;
  logic [2:0] b_col;
  logic [1:0] b_row;

  burst_packer_if #(.DATA_W(PW), .USER_W(UW)) a_s ();
  burst_packer_if #(.DATA_W(WW), .USER_W(UW)) a_m ();
  burst_packer_if #(.DATA_W(PW), .USER_W(UW)) b_s ();
  burst_packer_if #(.DATA_W(WW), .USER_W(UW)) b_m ();

  burst_packer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(P), .USER_WIDTH(UW),
                 .OUT_ROWS(10), .OUT_COLS(10)) dut_a (
    .clk(clk), .srst(srst), .ap_start(a_start), .ap_done(a_done),
    .s_axis(a_s), .m_axis(a_m), .cnt_col(a_col), .cnt_row(a_row));

  burst_packer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(P), .USER_WIDTH(UW),
                 .OUT_ROWS(3), .OUT_COLS(7)) dut_b (
    .clk(clk), .srst(srst), .ap_start(b_start), .ap_done(b_done),
    .s_axis(b_s), .m_axis(b_m), .cnt_col(b_col), .cnt_row(b_row));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit a_bp    = 1'b0;
  bit a_in_frame = 1'b0;
  bit b_in_frame = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output ready: random for DUT A when backpressure is enabled, otherwise always ready.
  initial begin
    a_m.tready = 1'b1;
    b_m.tready = 1'b1;
  end
  always @(posedge clk) begin
    #1;
    a_m.tready = a_bp ? 1'($urandom % 2) : 1'b1;
    b_m.tready = 1'b1;
  end

  // ---------------- model + compare for DUT A ----------------
  logic [PW-1:0] a_pix [A_F];
  logic [UW-1:0] a_usr [A_F];
  logic [WW-1:0] a_words [16];
  logic [UW-1:0] a_wuser [16];
  int a_npix = 0, a_nword = 0, a_nwords_last = 0, a_done_exp = -1, a_done_cnt = 0;
  bit a_pv = 1'b0;
  logic [WW-1:0] a_pd;
  logic [UW-1:0] a_pu;
  logic          a_pl;

  always @(negedge clk) begin : mon_a
    logic [WW-1:0] ew;
    int idx;
    if (srst) begin
      a_npix = 0; a_nword = 0; a_pv = 1'b0; a_done_exp = -1;
      for (int i = 0; i < A_F; i++) a_pix[i] = '1;
    end else begin
      if (a_pv) begin
        chk("a_hold_valid", a_m.tvalid, 1);
        chk("a_hold_data", a_m.tdata, a_pd);
        chk("a_hold_user", a_m.tuser, a_pu);
        chk("a_hold_last", a_m.tlast, a_pl);
      end
      if (a_in_frame && a_s.tvalid && !a_s.tready)
        chk("a_tready_drop", ((a_npix % P == P - 1) || (a_npix == A_F - 1)) && a_m.tvalid && !a_m.tready, 1);
      if (a_s.tvalid && a_s.tready) begin
        chk("a_cnt_col", a_col, a_npix % A_C);
        chk("a_cnt_row", a_row, a_npix / A_C);
        a_pix[a_npix] = a_s.tdata;
        a_usr[a_npix] = a_s.tuser;
        a_npix++;
      end
      if (a_m.tvalid && a_m.tready) begin
        ew = '0;
        for (int k = 0; k < P; k++) begin
          idx = a_nword * P + k;
          if (idx < A_F) ew[k*PW +: PW] = a_pix[idx];
        end
        chk("a_word", a_m.tdata, ew);
        chk("a_tuser", a_m.tuser, a_usr[a_nword * P]);
        chk("a_tlast", a_m.tlast, a_nword == A_B - 1);
        a_words[a_nword] = a_m.tdata;
        a_wuser[a_nword] = a_m.tuser;
        a_nword++;
        if (a_nword == A_B) begin
          a_done_exp = cyc + 2;
          a_nwords_last = a_nword;
          a_npix = 0; a_nword = 0;
          for (int i = 0; i < A_F; i++) a_pix[i] = '1;
        end
      end
      if (a_done) begin
        chk("a_done_time", cyc, a_done_exp);
        a_done_cnt++;
        a_done_exp = -1;
      end
      a_pv = a_m.tvalid && !a_m.tready;
      a_pd = a_m.tdata; a_pu = a_m.tuser; a_pl = a_m.tlast;
    end
  end

  // ---------------- model + compare for DUT B ----------------
  logic [PW-1:0] b_pix [B_F];
  logic [UW-1:0] b_usr [B_F];
  logic [WW-1:0] b_words [8];
  int b_npix = 0, b_nword = 0, b_nwords_last = 0, b_done_exp = -1, b_done_cnt = 0;

  always @(negedge clk) begin : mon_b
    logic [WW-1:0] ew;
    int idx;
    if (srst) begin
      b_npix = 0; b_nword = 0; b_done_exp = -1;
      for (int i = 0; i < B_F; i++) b_pix[i] = '1;
    end else begin
      if (b_in_frame && b_s.tvalid && !b_s.tready)
        chk("b_tready_drop", ((b_npix % P == P - 1) || (b_npix == B_F - 1)) && b_m.tvalid && !b_m.tready, 1);
      if (b_s.tvalid && b_s.tready) begin
        chk("b_cnt_col", b_col, b_npix % B_C);
        chk("b_cnt_row", b_row, b_npix / B_C);
        b_pix[b_npix] = b_s.tdata;
        b_usr[b_npix] = b_s.tuser;
        b_npix++;
      end
      if (b_m.tvalid && b_m.tready) begin
        ew = '0;
        for (int k = 0; k < P; k++) begin
          idx = b_nword * P + k;
          if (idx < B_F) ew[k*PW +: PW] = b_pix[idx];
        end
        chk("b_word", b_m.tdata, ew);
        chk("b_tuser", b_m.tuser, b_usr[b_nword * P]);
        chk("b_tlast", b_m.tlast, b_nword == B_B - 1);
        b_words[b_nword] = b_m.tdata;
        b_nword++;
        if (b_nword == B_B) begin
          b_done_exp = cyc + 2;
          b_nwords_last = b_nword;
          b_npix = 0; b_nword = 0;
        end
      end
      if (b_done) begin
        chk("b_done_time", cyc, b_done_exp);
        b_done_cnt++;
        b_done_exp = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    if (sel) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic send(input bit sel, input int n, input logic [1:0] u0, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int guard;
      bit hs;
      guard = 0;
      hs = 1'b0;
      if (sel) begin
        b_s.tvalid = 1'b1; b_s.tdata = PW'(i); b_s.tuser = (i == 0) ? u0 : 2'b00;
      end else begin
        a_s.tvalid = 1'b1; a_s.tdata = PW'(i); a_s.tuser = (i == 0) ? u0 : 2'b00;
      end
      do begin
        @(negedge clk);
        hs = sel ? b_s.tready : a_s.tready;
        if (!hs) stalls++;
        @(posedge clk); #1;
        guard++;
      end while (!hs && guard < 1000);
      if (!hs) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (sel) b_s.tvalid = 1'b0; else a_s.tvalid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sel ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(sel ? "b_done_seen" : "a_done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st;
    srst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tuser = '0; a_s.tlast = 1'b0;
    b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tuser = '0; b_s.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_done", a_done, 0);
    chk("rst_s_tready", a_s.tready, 0);
    chk("rst_m_tvalid", a_m.tvalid, 0);
    chk("rst_m_tlast", a_m.tlast, 0);
    chk("rst_m_tdata", a_m.tdata, 0);
    chk("rst_cnt", {a_col, a_row}, 0);
    @(posedge clk); #1;
    srst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: pixels 0..99 with the output always ready.
    a_bp = 1'b0;
    start_frame(0);
    a_in_frame = 1'b1;
    send(0, 100, 2'b00, st);
    a_in_frame = 1'b0;
    chk("a_t1_stalls", st, 0);
    wait_done(0);
    chk("a_t1_nwords", a_nwords_last, 10);
    chk("a_t1_w0_l0", a_words[0][0 +: PW], 0);
    chk("a_t1_w3_l5", a_words[3][50 +: PW], 35);
    chk("a_t1_w9_l0", a_words[9][0 +: PW], 90);
    chk("a_t1_w9_l9", a_words[9][90 +: PW], 99);
    chk("a_t1_done_cnt", a_done_cnt, 1);

    // Frame 2: random output backpressure.
    a_bp = 1'b1;
    start_frame(0);
    a_in_frame = 1'b1;
    send(0, 100, 2'b00, st);
    a_in_frame = 1'b0;
    wait_done(0);
    a_bp = 1'b0;
    chk("a_t2_nwords", a_nwords_last, 10);
    chk("a_t2_w7_l4", a_words[7][40 +: PW], 74);
    chk("a_t2_done_cnt", a_done_cnt, 2);

    // Frame 3: reset after 37 pixels, then a clean frame.
    start_frame(0);
    a_in_frame = 1'b1;
    send(0, 37, 2'b00, st);
    a_in_frame = 1'b0;
    srst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("srst_done", a_done, 0);
    chk("srst_s_tready", a_s.tready, 0);
    chk("srst_m_tvalid", a_m.tvalid, 0);
    chk("srst_m_tlast", a_m.tlast, 0);
    chk("srst_m_tdata", a_m.tdata, 0);
    chk("srst_m_tuser", a_m.tuser, 0);
    chk("srst_cnt", {a_col, a_row}, 0);
    @(posedge clk); #1;
    srst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("srst_no_done", a_done_cnt, 2);
    start_frame(0);
    a_in_frame = 1'b1;
    send(0, 100, 2'b00, st);
    a_in_frame = 1'b0;
    wait_done(0);
    chk("a_t3_w3_l7", a_words[3][70 +: PW], 37);
    chk("a_t3_w0_l1", a_words[0][10 +: PW], 1);
    chk("a_t3_done_cnt", a_done_cnt, 3);

    // Frame 4: spurious ap_start mid-frame, tuser=01 on pixel 0.
    start_frame(0);
    a_in_frame = 1'b1;
    fork
      send(0, 100, 2'b01, st);
      begin
        repeat (20) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
      end
    join
    a_in_frame = 1'b0;
    wait_done(0);
    chk("a_t4_nwords", a_nwords_last, 10);
    chk("a_t4_user_w0", a_wuser[0], 2'b01);
    chk("a_t4_user_w1", a_wuser[1], 2'b00);
    chk("a_t4_user_w9", a_wuser[9], 2'b00);
    chk("a_t4_w2_l3", a_words[2][30 +: PW], 23);
    chk("a_t4_done_cnt", a_done_cnt, 4);

    // Frame on the 3x7 instance: partial final burst.
    start_frame(1);
    b_in_frame = 1'b1;
    send(1, 21, 2'b00, st);
    b_in_frame = 1'b0;
    wait_done(1);
    chk("b_nwords", b_nwords_last, 3);
    chk("b_w1_l0", b_words[1][0 +: PW], 10);
    chk("b_w2_l0", b_words[2][0 +: PW], 20);
    chk("b_w2_pad", b_words[2][WW-1:PW], 0);
    chk("b_done_cnt", b_done_cnt, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
